// File: rtl/instr_fetch_queue_pkg.sv
// rtl/instr_fetch_queue_pkg.sv - shared types and constants for the fetch stage
package instr_fetch_queue_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h00000013;

  typedef enum logic [6:0] {
    OPC_LOAD   = 7'b0000011,
    OPC_FENCE  = 7'b0001111,
    OPC_IMM    = 7'b0010011,
    OPC_AUIPC  = 7'b0010111,
    OPC_STORE  = 7'b0100011,
    OPC_REG    = 7'b0110011,
    OPC_LUI    = 7'b0110111,
    OPC_BRANCH = 7'b1100011,
    OPC_JALR   = 7'b1100111,
    OPC_JAL    = 7'b1101111,
    OPC_SYSTEM = 7'b1110011
  } rv32i_opcode;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    DISCARD
  } fetch_state_t;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/instr_fetch_queue_if.sv
// rtl/instr_fetch_queue_if.sv - imem, redirect and decode handshakes of the fetch stage
interface instr_fetch_queue_if;
  import instr_fetch_queue_pkg::*;

  logic        imem_read;
  logic [31:0] imem_address;
  logic        imem_resp;
  logic [31:0] imem_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        dec_ready;
  logic        dec_valid;
  logic [31:0] dec_instr;
  logic [31:0] dec_pc;
  rv32i_opcode dec_opcode;
  logic [2:0]  dec_funct3;
  logic [6:0]  dec_funct7;

  modport master (
    output imem_read, imem_address,
    input  imem_resp, imem_rdata,
    input  redirect, redirect_pc,
    input  dec_ready,
    output dec_valid, dec_instr, dec_pc, dec_opcode, dec_funct3, dec_funct7
  );

  modport slave (
    input  imem_read, imem_address,
    output imem_resp, imem_rdata,
    output redirect, redirect_pc,
    output dec_ready,
    input  dec_valid, dec_instr, dec_pc, dec_opcode, dec_funct3, dec_funct7
  );

endinterface

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - power-of-2 FIFO of fetched {pc, instr} entries with flush
module fetch_queue
  import instr_fetch_queue_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  fetch_entry_t               push_entry,
  input  logic                       pop,
  input  logic                       flush,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output fetch_entry_t               head
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  fetch_entry_t  mem_q [DEPTH];
  logic [PW-1:0] wptr_q, wptr_d;
  logic [PW-1:0] rptr_q, rptr_d;
  logic [CW-1:0] count_q, count_d;

  // Pointers are exactly log2(DEPTH) wide, so they wrap without a compare.
  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (flush) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end else begin
      if (push) wptr_d = wptr_q + PW'(1);
      if (pop)  rptr_d = rptr_q + PW'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !flush) mem_q[wptr_q] <= push_entry;
  end

  assign count = count_q;
  assign head  = mem_q[rptr_q];

endmodule

// File: rtl/instr_fetch_queue.sv
// rtl/instr_fetch_queue.sv - fetch PC, single-outstanding imem FSM and decode-facing queue head
module instr_fetch_queue
  import instr_fetch_queue_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = 32'h00000060,
  parameter int          QUEUE_DEPTH = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  instr_fetch_queue_if.master bus
);

  localparam int CW = $clog2(QUEUE_DEPTH+1);
  localparam logic [CW:0] DEPTH_W = (CW+1)'(QUEUE_DEPTH);

  fetch_state_t  state_q, state_d;
  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   addr_q, addr_d;
  logic [CW-1:0] count;
  logic [CW:0]   count_after_push;
  fetch_entry_t  head;
  fetch_entry_t  push_entry;
  logic          dec_valid;
  logic          pop;
  logic          push;
  logic [31:0]   target_pc;
  logic [31:0]   dec_instr;

  assign target_pc  = word_align(bus.redirect_pc);
  assign dec_valid  = (count != '0);
  assign pop        = dec_valid && bus.dec_ready && !bus.redirect;
  assign push       = bus.imem_resp && (state_q == REQ) && !bus.redirect;
  assign push_entry = '{pc: addr_q, instr: bus.imem_rdata};

  // Occupancy once this response lands; the in-flight slot is already reserved.
  assign count_after_push = {1'b0, count} + (CW+1)'(1) - (CW+1)'(pop);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (bus.redirect || ({1'b0, count} < DEPTH_W)) state_d = REQ;
      end
      REQ: begin
        if (bus.imem_resp) begin
          state_d = (bus.redirect || (count_after_push < DEPTH_W)) ? REQ : IDLE;
        end else if (bus.redirect) begin
          state_d = DISCARD;
        end
      end
      DISCARD: begin
        if (bus.imem_resp) state_d = REQ;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    if (bus.redirect)  fetch_pc_d = target_pc;
    else if (push)     fetch_pc_d = fetch_pc_q + 32'd4;
  end

  // The address is frozen while a handshake is open, even across a redirect.
  always_comb begin
    addr_d = fetch_pc_d;
    if ((state_q != IDLE) && !bus.imem_resp) addr_d = addr_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      fetch_pc_q <= RESET_PC;
      addr_q     <= RESET_PC;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      addr_q     <= addr_d;
    end
  end

  fetch_queue #(
    .DEPTH (QUEUE_DEPTH)
  ) u_queue (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (push),
    .push_entry (push_entry),
    .pop        (pop),
    .flush      (bus.redirect),
    .count      (count),
    .head       (head)
  );

  assign dec_instr      = dec_valid ? head.instr : NOP_INSTR;
  assign bus.imem_read    = (state_q != IDLE);
  assign bus.imem_address = addr_q;
  assign bus.dec_valid    = dec_valid;
  assign bus.dec_instr    = dec_instr;
  assign bus.dec_pc       = dec_valid ? head.pc : 32'h0;
  assign bus.dec_opcode   = rv32i_opcode'(dec_instr[6:0]);
  assign bus.dec_funct3   = dec_instr[14:12];
  assign bus.dec_funct7   = dec_instr[31:25];

endmodule
